// File: rtl/fifo2axis.sv
//==============================================================================
// Module   : fifo2axis
// Purpose  : FIFO-write to AXI-Stream master adapter with a 2-entry output
//            buffer and a programmed packet length; TLAST marks the final beat.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fifo2axis #(
    parameter int DATA_WIDTH  = 64,
    parameter int LEN_WIDTH   = 16,
    parameter int FULL_ACTIVE = 1
) (
    input  logic                  ACC_CLK,
    input  logic                  ARESETN,
    input  logic                  CTRL_ALLOW,
    input  logic [LEN_WIDTH-1:0]  CTRL_LENGTH,
    output logic                  CTRL_READY,
    output logic                  CTRL_FINISHED,
    input  logic [DATA_WIDTH-1:0] FIFO_DIN,
    input  logic                  FIFO_WRITE,
    output logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] AXIS_TDATA,
    output logic                  AXIS_TVALID,
    output logic                  AXIS_TLAST,
    input  logic                  AXIS_TREADY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data [2];
    logic [1:0]            r_last;
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_count;
    logic [1:0]            w_count_nxt;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_wr_cnt;
    logic [LEN_WIDTH-1:0]  r_sent_cnt;
    logic [LEN_WIDTH:0]    w_wr_inc;
    logic [LEN_WIDTH:0]    w_sent_inc;
    logic                  w_wr_last;
    logic                  w_sent_last;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_valid;
    logic                  w_start;

    // Counters compare one bit wider so a maximum-length packet never wraps.
    assign w_wr_inc    = {1'b0, r_wr_cnt} + {{LEN_WIDTH{1'b0}}, 1'b1};
    assign w_sent_inc  = {1'b0, r_sent_cnt} + {{LEN_WIDTH{1'b0}}, 1'b1};
    assign w_wr_last   = (w_wr_inc == {1'b0, r_len});
    assign w_sent_last = (w_sent_inc == {1'b0, r_len});

    // Full is built only from registers, keeping TREADY off the FULL path.
    assign w_full  = (r_state != S_RUN) | (r_count == 2'd2) | (r_wr_cnt == r_len);
    assign w_push  = FIFO_WRITE & ~w_full;
    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid & AXIS_TREADY;
    assign w_start = CTRL_ALLOW & ((r_state == S_IDLE) | (r_state == S_DONE));

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (CTRL_ALLOW) begin
                    w_state_nxt = (CTRL_LENGTH == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_push && w_wr_last) begin
                    w_state_nxt = (w_count_nxt == 2'd0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_sent_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACC_CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge ACC_CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_len      <= '0;
            r_wr_cnt   <= '0;
            r_sent_cnt <= '0;
        end else if (w_start) begin
            r_len      <= CTRL_LENGTH;
            r_wr_cnt   <= '0;
            r_sent_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_cnt <= w_wr_inc[LEN_WIDTH-1:0];
            end
            if (w_pop) begin
                r_sent_cnt <= w_sent_inc[LEN_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge ACC_CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= 2'b00;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_tail] <= FIFO_DIN;
                r_last[r_tail] <= w_wr_last;
                r_tail         <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= w_count_nxt;
        end
    end

    assign AXIS_TDATA    = r_data[r_head];
    assign AXIS_TVALID   = w_valid;
    assign AXIS_TLAST    = w_valid & r_last[r_head];
    assign CTRL_READY    = (r_state == S_IDLE) | (r_state == S_DONE);
    assign CTRL_FINISHED = (r_state == S_DONE);
    assign FIFO_FULL     = (FULL_ACTIVE != 0) ? w_full : ~w_full;

endmodule

`default_nettype wire

// File: tb/tb_fifo2axis.sv
//==============================================================================
// Module   : tb_fifo2axis
// Purpose  : Scoreboard bench for fifo2axis (active-high and active-low FULL).
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo2axis;
    localparam int DW = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          allow;
    logic [LW-1:0] len;
    logic [DW-1:0] din;
    logic          wr;
    logic          tready;

    logic          h_ready, h_fin, h_full, h_tvalid, h_tlast;
    logic [DW-1:0] h_tdata;
    logic          l_ready, l_fin, l_full, l_tvalid, l_tlast;
    logic [DW-1:0] l_tdata;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   mon_e;
    bit            mon_en = 1'b0;
    int            beat_cnt = 0;
    int            last_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    bit            wr_abort = 1'b0;
    bit            wr_busy  = 1'b0;
    int            wr_acc   = 0;
    bit            rand_en  = 1'b0;

    fifo2axis #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .FULL_ACTIVE(1)) u_dut_hi (
        .ACC_CLK(clk), .ARESETN(rst_n), .CTRL_ALLOW(allow), .CTRL_LENGTH(len),
        .CTRL_READY(h_ready), .CTRL_FINISHED(h_fin), .FIFO_DIN(din),
        .FIFO_WRITE(wr), .FIFO_FULL(h_full), .AXIS_TDATA(h_tdata),
        .AXIS_TVALID(h_tvalid), .AXIS_TLAST(h_tlast), .AXIS_TREADY(tready)
    );

    fifo2axis #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .FULL_ACTIVE(0)) u_dut_lo (
        .ACC_CLK(clk), .ARESETN(rst_n), .CTRL_ALLOW(allow), .CTRL_LENGTH(len),
        .CTRL_READY(l_ready), .CTRL_FINISHED(l_fin), .FIFO_DIN(din),
        .FIFO_WRITE(wr), .FIFO_FULL(l_full), .AXIS_TDATA(l_tdata),
        .AXIS_TVALID(l_tvalid), .AXIS_TLAST(l_tlast), .AXIS_TREADY(tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and enforces AXIS stability.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", {63'd0, h_tvalid}, 64'd1);
                check("stall_data", h_tdata, prev_data);
                check("stall_last", {63'd0, h_tlast}, {63'd0, prev_last});
            end
            if (h_tvalid && tready) begin
                beat_cnt++;
                if (h_tlast) last_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got data %0h, expected no beat", h_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_data", h_tdata, mon_e[DW-1:0]);
                    check("beat_last", {63'd0, h_tlast}, {63'd0, mon_e[DW]});
                    check("lo_beat_data", l_tdata, mon_e[DW-1:0]);
                    check("lo_beat_valid", {63'd0, l_tvalid}, 64'd1);
                end
            end
            prev_stall = h_tvalid && !tready;
            prev_data  = h_tdata;
            prev_last  = h_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_pkt(input int n, input logic [DW-1:0] base);
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = base + DW'(k);
            exp_q.push_back({(k == n - 1), d});
        end
        beat_cnt = 0;
        last_cnt = 0;
        @(posedge clk); #1;
        allow = 1'b1;
        len   = LW'(n);
        @(posedge clk); #1;
        allow = 1'b0;
    endtask

    // Writer holds each word on FIFO_DIN until a cycle where FULL is clear.
    task automatic write_packet(input logic [DW-1:0] base, input int n);
        int i = 0;
        int budget = 3000;
        wr_acc = 0;
        while (i < n && !wr_abort && budget > 0) begin
            @(posedge clk); #1;
            if (wr_abort) break;
            din = base + DW'(i);
            wr  = 1'b1;
            @(negedge clk);
            if (h_full == 1'b0) begin
                i++;
                wr_acc = i;
            end
            budget--;
        end
        @(posedge clk); #1;
        wr = 1'b0;
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL writer_timeout: got %0d words written, expected %0d", i, n);
        end
        wr_busy = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (h_fin !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("finished", {63'd0, h_fin}, 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_writer();
        int c = 0;
        while (wr_busy && c < 300) begin
            @(negedge clk);
            c++;
        end
        check("writer_done", {63'd0, wr_busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; allow = 1'b0; len = '0; din = '0; wr = 1'b0; tready = 1'b0;
        #2;
        check("rst_tvalid", {63'd0, h_tvalid}, 64'd0);
        check("rst_tlast", {63'd0, h_tlast}, 64'd0);
        check("rst_tdata", h_tdata, 64'd0);
        check("rst_ready", {63'd0, h_ready}, 64'd1);
        check("rst_finished", {63'd0, h_fin}, 64'd0);
        check("rst_full_hi", {63'd0, h_full}, 64'd1);
        check("rst_full_lo", {63'd0, l_full}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Length 4, TREADY high, consecutive writes: one-cycle latency per beat.
        tready = 1'b1;
        start_pkt(4, 64'hA0);
        for (int i = 0; i < 4; i++) begin
            din = 64'hA0 + 64'(i);
            wr  = 1'b1;
            @(negedge clk);
            check("s1_full_hi", {63'd0, h_full}, 64'd0);
            check("s1_full_lo", {63'd0, l_full}, 64'd1);
            if (i > 0) check("s1_valid", {63'd0, h_tvalid}, 64'd1);
            @(posedge clk); #1;
        end
        wr = 1'b0;
        @(negedge clk);
        check("s1_last_beat", {63'd0, h_tlast}, 64'd1);
        check("s1_last_data", h_tdata, 64'hA3);
        check("s1_full_after4", {63'd0, h_full}, 64'd1);
        check("s1_full_lo_after4", {63'd0, l_full}, 64'd0);
        check("s1_fin_pending", {63'd0, h_fin}, 64'd0);
        @(negedge clk);
        check("s1_fin", {63'd0, h_fin}, 64'd1);
        check("s1_lo_fin", {63'd0, l_fin}, 64'd1);
        check("s1_idle_valid", {63'd0, h_tvalid}, 64'd0);
        check("s1_beats", 64'(beat_cnt), 64'd4);
        check("s1_lasts", 64'(last_cnt), 64'd1);

        // Length 8 with TREADY low: only two words fit before FULL asserts.
        tready = 1'b0;
        start_pkt(8, 64'hB00);
        wr_busy = 1'b1;
        fork write_packet(64'hB00, 8); join_none
        repeat (8) @(negedge clk);
        check("s2_accepted", 64'(wr_acc), 64'd2);
        check("s2_full_hi", {63'd0, h_full}, 64'd1);
        check("s2_full_lo", {63'd0, l_full}, 64'd0);
        check("s2_head_data", h_tdata, 64'hB00);
        check("s2_head_valid", {63'd0, h_tvalid}, 64'd1);
        @(posedge clk); #1;
        tready = 1'b1;
        wait_done(200);
        wait_writer();
        check("s2_beats", 64'(beat_cnt), 64'd8);
        check("s2_lasts", 64'(last_cnt), 64'd1);

        // Length 100 with random TREADY.
        rand_en = 1'b1;
        fork
            begin
                while (rand_en) begin
                    @(posedge clk); #1;
                    tready = 1'($urandom_range(0, 1));
                end
                tready = 1'b1;
            end
        join_none
        start_pkt(100, 64'h1000);
        wr_busy = 1'b1;
        fork write_packet(64'h1000, 100); join_none
        wait_done(3000);
        rand_en = 1'b0;
        wait_writer();
        repeat (3) @(negedge clk);
        check("s3_beats", 64'(beat_cnt), 64'd100);
        check("s3_lasts", 64'(last_cnt), 64'd1);

        // Zero-length packet, then a length-3 packet.
        tready = 1'b1;
        start_pkt(0, 64'h0);
        @(negedge clk);
        check("s4_fin", {63'd0, h_fin}, 64'd1);
        check("s4_full_hi", {63'd0, h_full}, 64'd1);
        check("s4_full_lo", {63'd0, l_full}, 64'd0);
        check("s4_valid", {63'd0, h_tvalid}, 64'd0);
        repeat (3) @(negedge clk);
        check("s4_beats", 64'(beat_cnt), 64'd0);
        start_pkt(3, 64'hC0);
        @(negedge clk);
        check("s4_fin_cleared", {63'd0, h_fin}, 64'd0);
        check("s4_ready_busy", {63'd0, h_ready}, 64'd0);
        wr_busy = 1'b1;
        fork write_packet(64'hC0, 3); join_none
        wait_done(200);
        wait_writer();
        check("s4_beats3", 64'(beat_cnt), 64'd3);
        check("s4_lasts3", 64'(last_cnt), 64'd1);

        // Reset in the middle of a length-5 packet with two words buffered.
        tready = 1'b0;
        start_pkt(5, 64'hD0);
        wr_busy = 1'b1;
        fork write_packet(64'hD0, 5); join_none
        repeat (6) @(negedge clk);
        check("s6_accepted", 64'(wr_acc), 64'd2);
        check("s6_valid_pre", {63'd0, h_tvalid}, 64'd1);
        @(posedge clk); #3;
        mon_en   = 1'b0;
        wr_abort = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("s6_rst_valid", {63'd0, h_tvalid}, 64'd0);
        check("s6_rst_last", {63'd0, h_tlast}, 64'd0);
        check("s6_rst_valid_lo", {63'd0, l_tvalid}, 64'd0);
        exp_q.delete();
        wait_writer();
        wr_abort = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_ready", {63'd0, h_ready}, 64'd1);
        check("s6_fin", {63'd0, h_fin}, 64'd0);
        check("s6_valid_post", {63'd0, h_tvalid}, 64'd0);
        mon_en = 1'b1;
        tready = 1'b1;
        start_pkt(2, 64'hE0);
        wr_busy = 1'b1;
        fork write_packet(64'hE0, 2); join_none
        wait_done(200);
        wait_writer();
        check("s6_beats", 64'(beat_cnt), 64'd2);
        check("s6_lasts", 64'(last_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo2axis.md
Name: fifo2axis

Overview:
- Downstream-side companion to the AXIS-to-FIFO input adapter: accepts accelerator results on a FIFO-write style interface and emits them as an AXI-Stream master packet of a programmed beat count, asserting TLAST on the final beat.
- Sits between the accelerator output and the DMA S2MM stream port.
- Uses the same CTRL_ALLOW / CTRL_READY / CTRL_FINISHED control handshake as the input adapter.
- Contains a 2-entry output buffer, so there is no combinational path from AXIS_TREADY to FIFO_FULL.

Parameters:
- DATA_WIDTH, 64, width of FIFO_DIN and AXIS_TDATA.
- LEN_WIDTH, 16, width of CTRL_LENGTH and of the internal beat counters.
- FULL_ACTIVE, 1, FIFO_FULL polarity: 1 = active high, 0 = active low.

Ports:
- ACC_CLK  in  1  single clock for the whole block.
- ARESETN  in  1  reset; asynchronous assert, active low.
- CTRL_ALLOW  in  1  start a packet; sampled only in IDLE or DONE.
- CTRL_LENGTH  in  LEN_WIDTH  beats in the packet; latched on the start cycle.
- CTRL_READY  out  1  high in IDLE or DONE (a new start will be accepted).
- CTRL_FINISHED  out  1  high in DONE; stays high until the next start.
- FIFO_DIN  in  DATA_WIDTH  write data from the accelerator.
- FIFO_WRITE  in  1  write strobe; ignored while full is asserted.
- FIFO_FULL  out  1  full flag, polarity set by FULL_ACTIVE.
- AXIS_TDATA  out  DATA_WIDTH  stream data, driven from buffer head.
- AXIS_TVALID  out  1  buffer non-empty.
- AXIS_TLAST  out  1  high when the head entry is the final beat.
- AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset (async, ARESETN low):
  - state = IDLE; buffer count = 0; write counter = 0; sent counter = 0; latched length = 0.
  - AXIS_TVALID = 0 and AXIS_TLAST = 0 immediately, without waiting for a clock.
  - CTRL_READY = 1, CTRL_FINISHED = 0.
  - FIFO_FULL asserted (1 if FULL_ACTIVE = 1, else 0).
  - AXIS_TDATA = 0.
- Internal full_i = (state != RUN) | (buf_count == 2) | (wr_cnt == len). FIFO_FULL = full_i if FULL_ACTIVE, else ~full_i. full_i derives only from registered state.
- Write accept: push = FIFO_WRITE & ~full_i. On push:
  - store {FIFO_DIN, last}, where last = (wr_cnt + 1 == len);
  - wr_cnt increments.
- Stream pop: pop = AXIS_TVALID & AXIS_TREADY.
  - Head advances; sent counter increments.
  - Push and pop in the same cycle are both performed; buf_count is unchanged.
- Latency: a word pushed at edge N is on AXIS_TDATA with AXIS_TVALID high after edge N, when the buffer was empty.
- Throughput: 1 beat per clock sustained while AXIS_TREADY is held high.
- AXI-Stream rules:
  - Once AXIS_TVALID is high, AXIS_TDATA and AXIS_TLAST hold stable until pop.
  - AXIS_TVALID never drops without a pop.
  - AXIS_TLAST is high only on the beat numbered len.
- State machine:
  - IDLE: on CTRL_ALLOW, latch CTRL_LENGTH and clear the counters. Go to RUN if the length is non-zero, else go to DONE.
  - RUN: on the push that makes wr_cnt == len, go to DRAIN. If the buffer also empties in that cycle, go directly to DONE.
  - DRAIN: no pushes accepted. Go to DONE on the pop of the TLAST beat.
  - DONE: CTRL_FINISHED = 1. On CTRL_ALLOW, behave as IDLE (latch, clear, go to RUN/DONE). The finished bit clears on the start edge.
- CTRL_ALLOW while in RUN or DRAIN is ignored; CTRL_LENGTH is not re-sampled.
- Length 0: no beats are emitted, no TLAST is driven, FIFO_FULL stays asserted, and CTRL_FINISHED goes high one cycle after the start.
- Length 2^LEN_WIDTH-1 is supported; the counters do not wrap within a packet.
- FIFO_WRITE while full is dropped silently; the data is not stored and wr_cnt is unchanged.
- Reset mid-packet: buffered data is discarded, the stream is aborted with no TLAST, and the block returns to IDLE.

Test Plan:
- Reset, then start with CTRL_LENGTH = 4 and AXIS_TREADY held at 1; write D0..D3 on consecutive cycles.
  - Four beats appear on consecutive cycles, each 1 cycle after its write; TLAST is high on D3 only.
  - CTRL_FINISHED rises the cycle after D3 is popped; FIFO_FULL is asserted from the 4th write onward.
- CTRL_LENGTH = 8, AXIS_TREADY low, writer continuously asserts FIFO_WRITE.
  - Exactly 2 words are accepted and FIFO_FULL asserts.
  - After AXIS_TREADY goes high, all 8 words arrive in order, TDATA is held stable during the stall, and TLAST is on beat 8.
- Randomised TREADY (50%) with CTRL_LENGTH = 100.
  - 100 beats in order, no lost or duplicated data, TLAST exactly once on beat 100.
  - TVALID never drops without a handshake.
- CTRL_LENGTH = 0 start → CTRL_FINISHED = 1 the next cycle, zero beats, FIFO_FULL held asserted. A second start with length 3 then completes normally.
- FULL_ACTIVE = 0 build: FIFO_FULL reads 0 when full or after reset and 1 when writes are accepted. The first scenario's data checks pass unchanged.
- Assert ARESETN low mid-packet (beat 2 of 5, buffer holding 2 entries).
  - AXIS_TVALID drops immediately without waiting for a clock edge; CTRL_READY = 1 after release.
  - A new length-2 packet emits only new data.
